// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC read-side logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, control vectors {CS,AD,RD,WR}, frame boundaries,
//           register address table and the frame-cycle-to-phase decode.
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_HOLD,
        ST_READ,
        ST_RECOV,
        ST_DONE
    } estado_t;

    // Control vectors, active-low {CS, AD, RD, WR}
    localparam logic [3:0] CTRL_IDLE = 4'b1111;
    localparam logic [3:0] CTRL_ADDR = 4'b0010;
    localparam logic [3:0] CTRL_RD   = 4'b0101;

    // Frame cycle boundaries (first cycle of each phase)
    localparam logic [4:0] FC_ADDR    = 5'd4;
    localparam logic [4:0] FC_HOLD    = 5'd10;
    localparam logic [4:0] FC_READ    = 5'd12;
    localparam logic [4:0] FC_RECOV   = 5'd20;
    localparam logic [4:0] FC_FIN     = 5'd31;
    localparam logic [4:0] FC_MUESTRA = 5'd19;

    localparam logic [7:0] DIR_SEG  = 8'h21;
    localparam logic [7:0] DIR_MIN  = 8'h22;
    localparam logic [7:0] DIR_HORA = 8'h23;
    localparam logic [7:0] DIR_DIA  = 8'h24;
    localparam logic [7:0] DIR_MES  = 8'h25;
    localparam logic [7:0] DIR_ANIO = 8'h26;

    function automatic logic [7:0] dir_reg(input logic [2:0] idx);
        case (idx)
            3'd0:    return DIR_SEG;
            3'd1:    return DIR_MIN;
            3'd2:    return DIR_HORA;
            3'd3:    return DIR_DIA;
            3'd4:    return DIR_MES;
            default: return DIR_ANIO;
        endcase
    endfunction

    // Cycles 0-3 (inter-frame gap) and 20-31 are both recovery.
    function automatic estado_t fase(input logic [4:0] fc);
        if (fc < FC_ADDR)       return ST_RECOV;
        else if (fc < FC_HOLD)  return ST_ADDR;
        else if (fc < FC_READ)  return ST_HOLD;
        else if (fc < FC_RECOV) return ST_READ;
        else                    return ST_RECOV;
    endfunction

endpackage

// File: rtl/rtc_lectura_if.sv
// Multiplexed 8-bit AD bus towards the RTC pad ring.
// Latency: n/a (wires only).
// Backpressure: none; the RTC has no wait signal, timing is fixed by the frame.
// master: drives ad_out/ad_oe/control, samples ad_in. slave: the pad/RTC side.
interface rtc_lectura_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [3:0] control;

    modport master (input ad_in, output ad_out, output ad_oe, output control);
    modport slave  (output ad_in, input ad_out, input ad_oe, input control);
endinterface

// File: rtl/rtc_ciclo_bus.sv
// Single-register bus frame generator: frame counter plus registered control/ad_oe/ad_out.
// Latency: outputs registered, reflect the current fc; muestra at fc=19, fin at fc=31.
// Backpressure: none; once started it free-runs frames until parar.
// Ports: clk, reset, arranque (start, fc<=0), parar (stop after last frame), dir (address),
//        fc, control, ad_oe, ad_out, muestra, fin.
module rtc_ciclo_bus
    import rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       arranque,
    input  logic       parar,
    input  logic [7:0] dir,
    output logic [4:0] fc,
    output logic [3:0] control,
    output logic       ad_oe,
    output logic [7:0] ad_out,
    output logic       muestra,
    output logic       fin
);

    logic       activo;
    logic [4:0] fc_sig;
    estado_t    fase_sig;

    // Bus outputs are decoded from the next fc so they are registered yet
    // aligned with the cycle that fc is about to enter.
    always_comb begin
        fc_sig   = (fc == FC_FIN) ? 5'd0 : fc + 5'd1;
        fase_sig = fase(fc_sig);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            activo  <= 1'b0;
            fc      <= 5'd0;
            control <= CTRL_IDLE;
            ad_oe   <= 1'b0;
            ad_out  <= 8'h00;
        end else if (arranque) begin
            activo  <= 1'b1;
            fc      <= 5'd0;
            control <= CTRL_IDLE;
            ad_oe   <= 1'b0;
            ad_out  <= 8'h00;
        end else if (activo && parar) begin
            activo  <= 1'b0;
            fc      <= 5'd0;
            control <= CTRL_IDLE;
            ad_oe   <= 1'b0;
            ad_out  <= 8'h00;
        end else if (activo) begin
            fc <= fc_sig;
            case (fase_sig)
                ST_ADDR: begin
                    control <= CTRL_ADDR;
                    ad_oe   <= 1'b1;
                    ad_out  <= dir;
                end
                ST_HOLD: begin
                    // CS/WR released but the address stays on the bus
                    control <= CTRL_IDLE;
                    ad_oe   <= 1'b1;
                    ad_out  <= dir;
                end
                ST_READ: begin
                    control <= CTRL_RD;
                    ad_oe   <= 1'b0;
                    ad_out  <= 8'h00;
                end
                default: begin
                    control <= CTRL_IDLE;
                    ad_oe   <= 1'b0;
                    ad_out  <= 8'h00;
                end
            endcase
        end
    end

    assign muestra = activo && (fc == FC_MUESTRA);
    assign fin     = activo && (fc == FC_FIN);

endmodule

// File: rtl/rtc_lectura.sv
// RTC read burst: reads six timekeeping registers and publishes them as one snapshot.
// Latency: listo pulses 193 clocks after the edge accepting leer; 194-clock repeat rate.
// Backpressure: leer only sampled in IDLE with ini_listo high; no queueing.
// Ports: clk, reset, ini_listo, leer, bus (AD bus master), ocupado, listo,
//        seg/min/hora/dia/mes/anio (raw BCD, change only on the listo edge).
module rtc_lectura
    import rtc_pkg::*;
#(
    parameter int N_REG   = 6,
    parameter int T_FRAME = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ini_listo,
    input  logic                leer,
    rtc_lectura_if.master       bus,
    output logic                ocupado,
    output logic                listo,
    output logic [7:0]          seg,
    output logic [7:0]          min,
    output logic [7:0]          hora,
    output logic [7:0]          dia,
    output logic [7:0]          mes,
    output logic [7:0]          anio
);

    estado_t    estado, estado_sig;
    logic [2:0] idx;
    logic [7:0] sombra [N_REG];
    logic       arranque, parar, publicar;
    logic [4:0] fc;
    logic       muestra, fin;
    logic [3:0] control_q;
    logic       ad_oe_q;
    logic [7:0] ad_out_q;

    rtc_ciclo_bus u_ciclo (
        .clk      (clk),
        .reset    (reset),
        .arranque (arranque),
        .parar    (parar),
        .dir      (dir_reg(idx)),
        .fc       (fc),
        .control  (control_q),
        .ad_oe    (ad_oe_q),
        .ad_out   (ad_out_q),
        .muestra  (muestra),
        .fin      (fin)
    );

    assign bus.control = control_q;
    assign bus.ad_oe   = ad_oe_q;
    assign bus.ad_out  = ad_out_q;

    always_comb begin
        estado_sig = estado;
        arranque   = 1'b0;
        parar      = 1'b0;
        publicar   = 1'b0;
        case (estado)
            ST_IDLE: begin
                if (leer && ini_listo) begin
                    arranque   = 1'b1;
                    estado_sig = fase(5'd0);
                end
            end
            ST_ADDR, ST_HOLD, ST_READ, ST_RECOV: begin
                if (fin && (idx == 3'(N_REG - 1))) begin
                    parar      = 1'b1;
                    estado_sig = ST_DONE;
                end else begin
                    estado_sig = fase(fin ? 5'd0 : fc + 5'd1);
                end
            end
            ST_DONE: begin
                publicar   = 1'b1;
                estado_sig = ST_IDLE;
            end
            default: estado_sig = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado  <= ST_IDLE;
            idx     <= 3'd0;
            ocupado <= 1'b0;
            listo   <= 1'b0;
            seg     <= 8'h00;
            min     <= 8'h00;
            hora    <= 8'h00;
            dia     <= 8'h00;
            mes     <= 8'h00;
            anio    <= 8'h00;
            for (int i = 0; i < N_REG; i++) sombra[i] <= 8'h00;
        end else begin
            estado <= estado_sig;
            listo  <= publicar;
            if (arranque) begin
                idx     <= 3'd0;
                ocupado <= 1'b1;
            end
            // Last RD-low cycle: the RTC has had 8 cycles to drive the bus
            if (muestra) sombra[idx] <= bus.ad_in;
            if (fin && !parar) idx <= idx + 3'd1;
            // All six outputs move on one edge so a reader never sees a mix
            if (publicar) begin
                ocupado <= 1'b0;
                seg     <= sombra[0];
                min     <= sombra[1];
                hora    <= sombra[2];
                dia     <= sombra[3];
                mes     <= sombra[4];
                anio    <= sombra[5];
            end
        end
    end

endmodule

// File: tb/tb_rtc_lectura.sv
// Directed bench for rtc_lectura with a behavioural RTC answering on the AD bus.
// Latency: n/a.
// Backpressure: n/a.
module tb_rtc_lectura;

    logic clk;
    logic reset;
    logic ini_listo;
    logic leer;
    logic ocupado, listo;
    logic [7:0] seg, min, hora, dia, mes, anio;

    rtc_lectura_if bus ();

    rtc_lectura #(.N_REG(6), .T_FRAME(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ini_listo (ini_listo),
        .leer      (leer),
        .bus       (bus),
        .ocupado   (ocupado),
        .listo     (listo),
        .seg       (seg),
        .min       (min),
        .hora      (hora),
        .dia       (dia),
        .mes       (mes),
        .anio      (anio)
    );

    int checks = 0;
    int errs   = 0;
    logic [7:0] dat [6];
    logic [7:0] dir_lat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RTC model: latch the address during the ADDR window, answer with dat[]
    initial begin
        bus.ad_in = 8'hFF;
        dir_lat   = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.ad_oe && bus.control == 4'b0010) dir_lat = bus.ad_out;
            if (dir_lat >= 8'h21 && dir_lat <= 8'h26)
                bus.ad_in = dat[int'(dir_lat) - 33];
            else
                bus.ad_in = 8'hFF;
        end
    end

    function automatic logic [47:0] salidas();
        return {seg, min, hora, dia, mes, anio};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cargar(input logic [47:0] v);
        for (int i = 0; i < 6; i++) dat[i] = v[47 - 8*i -: 8];
    endtask

    // Returns at cycle 0 of the burst (one clock after the accepting edge)
    task automatic aceptar();
        @(negedge clk);
        leer = 1'b1;
        @(negedge clk);
        leer = 1'b0;
    endtask

    task automatic correr(input string tag, input int poke_at,
                          input logic [47:0] viejo, input logic [47:0] nuevo);
        int lat = -1;
        int bad_bus = 0;
        int bad_atom = 0;
        int n = 0;
        int c;
        logic [3:0] ec;
        logic       eo;
        logic [7:0] ea;
        while (lat < 0 && n < 260) begin
            if (n > 0) @(negedge clk);
            leer = (n == poke_at);
            if (n == 0) chk({tag, "_ocupado_start"}, 64'(ocupado), 64'd1);
            c  = n % 32;
            ea = 8'h21 + 8'(n / 32);
            if (n < 192) begin
                ec = (c >= 4 && c <= 9) ? 4'b0010 : (c >= 12 && c <= 19) ? 4'b0101 : 4'b1111;
                eo = (c >= 4 && c <= 11);
            end else begin
                ec = 4'b1111;
                eo = 1'b0;
            end
            if (n < 192 && c == 4)
                chk({tag, "_addr_window"}, 64'({bus.control, bus.ad_out}), 64'({4'b0010, ea}));
            if (bus.control !== ec || bus.ad_oe !== eo || (eo && bus.ad_out !== ea))
                bad_bus++;
            if (listo === 1'b1) lat = n;
            else if (salidas() !== viejo) bad_atom++;
            n++;
        end
        leer = 1'b0;
        chk({tag, "_listo_latency"}, 64'(lat), 64'd193);
        chk({tag, "_snapshot"}, 64'(salidas()), 64'(nuevo));
        chk({tag, "_ocupado_end"}, 64'(ocupado), 64'd0);
        chk({tag, "_bus_sequence_errs"}, 64'(bad_bus), 64'd0);
        chk({tag, "_atomicity_errs"}, 64'(bad_atom), 64'd0);
        @(negedge clk);
        chk({tag, "_listo_one_cycle"}, 64'(listo), 64'd0);
    endtask

    initial begin
        int bad;
        reset     = 1'b1;
        leer      = 1'b0;
        ini_listo = 1'b0;
        cargar(48'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_control", 64'(bus.control), 64'hF);
        chk("rst_ad_oe", 64'(bus.ad_oe), 64'd0);
        chk("rst_ad_out", 64'(bus.ad_out), 64'h00);
        chk("rst_flags", 64'({ocupado, listo}), 64'd0);
        chk("rst_outputs", 64'(salidas()), 64'h0);

        // Idle: no request for 100 clocks
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (listo !== 1'b0 || bus.control !== 4'b1111 || bus.ad_oe !== 1'b0) bad++;
        end
        chk("idle_100_errs", 64'(bad), 64'd0);
        chk("idle_outputs", 64'(salidas()), 64'h0);

        // Gate: leer ignored while initialisation is incomplete
        aceptar();
        bad = 0;
        repeat (40) begin
            if (ocupado !== 1'b0 || bus.control !== 4'b1111 || bus.ad_oe !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("gate_errs", 64'(bad), 64'd0);

        // Full burst
        ini_listo = 1'b1;
        cargar(48'h453012071124);
        aceptar();
        correr("b1", -1, 48'h0, 48'h453012071124);

        // Changed data, leer poked during frame 3; old values held until DONE
        cargar(48'h595923311299);
        aceptar();
        ini_listo = 1'b0;   // falling mid-burst must not abort
        correr("b2", 3*32 + 5, 48'h453012071124, 48'h595923311299);
        ini_listo = 1'b1;
        bad = 0;
        repeat (250) begin
            @(negedge clk);
            if (listo !== 1'b0 || ocupado !== 1'b0) bad++;
        end
        chk("no_queued_burst_errs", 64'(bad), 64'd0);

        // Reset at frame 2, cycle 15
        cargar(48'h010203040506);
        aceptar();
        repeat (79) @(negedge clk);
        chk("pre_rst_read_phase", 64'(bus.control), 64'h5);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_bus", 64'({bus.control, bus.ad_oe, bus.ad_out}), 64'({4'b1111, 1'b0, 8'h00}));
        chk("midrst_flags", 64'({ocupado, listo}), 64'd0);
        chk("midrst_outputs", 64'(salidas()), 64'h0);
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (listo !== 1'b0 || ocupado !== 1'b0) bad++;
        end
        chk("post_rst_quiet_errs", 64'(bad), 64'd0);
        aceptar();
        correr("b3", -1, 48'h0, 48'h010203040506);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rtc_lectura.md
# rtc_lectura

Reads the six timekeeping registers of the external RTC over its multiplexed 8-bit AD bus. It is the read-side companion of the RTC initialisation block and uses the same 4-bit control vector: control[3]=CS, control[2]=AD, control[1]=RD, control[0]=WR, all active-low. It runs one read burst per request after initialisation has completed, then publishes the six captured bytes together as one atomic snapshot.

## Interface
Parameters:
- N_REG, 6: registers read per burst.
- T_FRAME, 32: clocks per single-register bus frame.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- ini_listo  in  1  high once RTC initialisation is complete. While low, `leer` is ignored.
- leer  in  1  read request. Sampled only in IDLE.
- ad_in  in  8  AD bus value from the pad.
- ad_out  out  8  AD bus drive value.
- ad_oe  out  1  AD pad output enable; the top level does the tristate.
- control  out  4  {CS, AD, RD, WR}, active-low.
- ocupado  out  1  high while a burst is in progress.
- listo  out  1  one-cycle pulse when a new snapshot is valid.
- seg, min, hora, dia, mes, anio  out  8 each  published register values, raw BCD.

## Operation
- Address list, indexed by 0..5: 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 anio.
- States:
  - IDLE.
  - ADDR: frame cycles 4–9.
  - HOLD: frame cycles 10–11.
  - READ: frame cycles 12–19.
  - RECOV: frame cycles 20–31, plus the inter-frame gap at cycles 0–3.
  - DONE.
- Frame counter fc: 5 bits, counts 0..31 and wraps to 0. Register index idx: 3 bits.
- IDLE → burst start: when `leer` = 1 and `ini_listo` = 1, set fc = 0, idx = 0, ocupado = 1.
- Outputs per frame cycle:
  - 0–3: control = 1111, ad_oe = 0.
  - 4–9 (ADDR): control = 0010, ad_oe = 1, ad_out = addr[idx].
  - 10–11 (HOLD): control = 1111, ad_oe = 1, ad_out = addr[idx].
  - 12–19 (READ): control = 0101, ad_oe = 0.
  - 20–31 (RECOV): control = 1111, ad_oe = 0.
- Capture: at frame cycle 19, sample `ad_in` into shadow[idx].
- End of frame: at fc = 31, if idx < 5 then idx increments and fc wraps to 0; if idx = 5, go to DONE.
- DONE, one cycle:
  - copy all six shadows to the outputs simultaneously;
  - listo = 1, ocupado = 0;
  - next state IDLE.
- Outputs change only in DONE. A partial burst never becomes visible.
- `leer` is ignored in every state except IDLE. There is no queueing.
- `ini_listo` falling mid-burst: the burst still completes.
- Reset, including mid-burst:
  - state = IDLE; fc = 0; idx = 0;
  - control = 1111, ad_oe = 0, ad_out = 0x00;
  - ocupado = 0, listo = 0;
  - all outputs and shadows = 0x00.
  - Reset takes priority over `leer` in the same cycle.

## Timing
- Frame cycle 0 of register 0 is the first clock after the edge that samples `leer`.
- Burst length: 6 × 32 = 192 clocks; listo rises 193 clocks after the accepting edge.
- With `leer` held high continuously, one burst runs every 194 clocks: DONE and IDLE each take one cycle.
- AD bus turnaround:
  - ad_oe falls at cycle 12, the same edge at which RD falls.
  - ad_oe rises no earlier than cycle 4 of the next frame.
  - There are 4 high-Z cycles between frames (cycles 0–3), plus the recovery cycles 20–31.
- Address held stable for 2 cycles after WR and CS rise (HOLD).
- Data sampled on the last RD-low cycle, cycle 19.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package rtc_pkg:
  - state enum;
  - control constants CTRL_IDLE = 1111, CTRL_ADDR = 0010, CTRL_RD = 0101;
  - frame boundary constants 4, 10, 12, 20, 31 and the sample point 19;
  - the six register addresses.
- Sub-module rtc_ciclo_bus: generates fc and the per-cycle control and ad_oe, takes an address input, and emits a `muestra` strobe at cycle 19 and a `fin` strobe at cycle 31.
- The top level holds the state machine, idx, the shadow registers and the publish logic.

## Test plan
- Reset then idle: `leer` = 0 for 100 clocks → control = 1111, ad_oe = 0, listo never asserted, all outputs 0x00.
- Gate: `ini_listo` = 0, pulse `leer` → ocupado stays 0 and the bus stays idle.
- Full burst:
  - stimulus: `ini_listo` = 1; bus model returns 0x45, 0x30, 0x12, 0x07, 0x11, 0x24 for addresses 0x21..0x26.
  - response: listo pulses 193 clocks after acceptance, and seg..anio equal those values.
  - also check each ADDR window shows ad_out = 0x21..0x26 with control = 0010.
- Ignored request: pulse `leer` at frame 3 of a burst → still exactly one listo, and the next burst starts only after a new `leer` seen in IDLE.
- Reset mid-burst:
  - stimulus: assert reset at frame 2, cycle 15.
  - response: next cycle control = 1111, ad_oe = 0, outputs 0x00, no listo.
  - then: a new `leer` runs a full, correct burst.
- Atomicity: run a second burst with changed bus data → outputs hold the old values until the DONE cycle, then all six change on the same edge.
